// File: rtl/axi_pkg.sv
// Shared AXI constants, FSM state encodings and response helper
// for the burst master and its beat counter.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WIDLE = 2'd0,
    WADDR = 2'd1,
    WDATA = 2'd2,
    WRESP = 2'd3
  } wr_state_e;

  typedef enum logic [1:0] {
    RIDLE = 2'd0,
    RADDR = 2'd1,
    RDATA = 2'd2
  } rd_state_e;

  function automatic logic [1:0] resp_max(
    input logic [1:0] a,
    input logic [1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_burst_beat_ctr.sv
// Burst beat counter: load beats-1, count down per beat, flag last.
// Ports: aclk, aresetn, load, len, beat in; last out.
module axi_burst_beat_ctr #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 load,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 beat,
  output logic                 last
);

  logic [LEN_WIDTH-1:0] cnt;

  // Decrement past zero wraps; owner FSM decides what that means.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (beat) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master: user commands -> INCR bursts, one txn per direction.
// Ports: aclk/aresetn, m_axi_* AXI4, u_wr_*/u_rd_* user; AXI_MASTER_ERR_LATCH_EN adds u_err*.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter  int ID_WIDTH   = 4,
  parameter  int TXN_ID     = 0,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int LEN_WIDTH  = 8,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [LEN_WIDTH-1:0]  m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [LEN_WIDTH-1:0]  m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [2:0]            m_axi_arprot,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic                  u_wr_req,
  output logic                  u_wr_gnt,
  input  logic [ADDR_WIDTH-1:0] u_wr_addr,
  input  logic [LEN_WIDTH-1:0]  u_wr_len,
  input  logic                  u_wr_rok,
  output logic                  u_wr_ren,
  input  logic [DATA_WIDTH-1:0] u_wr_data,
  input  logic [STRB_WIDTH-1:0] u_wr_strb,
  output logic                  u_wr_done,
  output logic [1:0]            u_wr_resp,
  input  logic                  u_rd_req,
  output logic                  u_rd_gnt,
  input  logic [ADDR_WIDTH-1:0] u_rd_addr,
  input  logic [LEN_WIDTH-1:0]  u_rd_len,
  input  logic                  u_rd_wok,
  output logic                  u_rd_wen,
  output logic [DATA_WIDTH-1:0] u_rd_data,
`ifdef AXI_MASTER_ERR_LATCH_EN
  output logic                  u_rd_done,
  output logic [1:0]            u_rd_resp,
  output logic                  u_err,
  output logic [ADDR_WIDTH-1:0] u_err_addr,
  input  logic                  u_err_clr
`else
  output logic                  u_rd_done,
  output logic [1:0]            u_rd_resp
`endif
);

  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));
  localparam logic [ID_WIDTH-1:0] AXID = ID_WIDTH'(TXN_ID);

  // IDs are constant and one txn is outstanding, so B/R IDs carry no info.
  logic unused_ids;
  assign unused_ids = ^{m_axi_bid, m_axi_rid};

  // ---------------- write channel ----------------
  wr_state_e             wr_st, wr_nx;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [LEN_WIDTH-1:0]  wr_len_q;
  logic                  wr_done_q;
  logic [1:0]            wr_resp_q;
  logic                  w_load, w_beat, w_last;

  always_comb begin
    wr_nx         = wr_st;
    u_wr_gnt      = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    unique case (wr_st)
      WIDLE: begin
        if (u_wr_req) begin
          u_wr_gnt = 1'b1;
          wr_nx    = WADDR;
        end
      end
      WADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) wr_nx = WDATA;
      end
      WDATA: begin
        m_axi_wvalid = u_wr_rok;
        if (u_wr_rok && m_axi_wready && w_last) wr_nx = WRESP;
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) wr_nx = WIDLE;
      end
      default: wr_nx = WIDLE;
    endcase
  end

  assign w_load = m_axi_awvalid & m_axi_awready;
  assign w_beat = m_axi_wvalid & m_axi_wready;

  axi_burst_beat_ctr #(.LEN_WIDTH(LEN_WIDTH)) u_w_ctr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (w_load),
    .len     (wr_len_q),
    .beat    (w_beat),
    .last    (w_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_st     <= WIDLE;
      wr_addr_q <= '0;
      wr_len_q  <= '0;
      wr_done_q <= 1'b0;
      wr_resp_q <= AXI_RESP_OKAY;
    end else begin
      wr_st     <= wr_nx;
      wr_done_q <= m_axi_bready & m_axi_bvalid;
      if (u_wr_gnt) begin
        wr_addr_q <= u_wr_addr;
        wr_len_q  <= u_wr_len;
      end
      if (m_axi_bready && m_axi_bvalid) wr_resp_q <= m_axi_bresp;
    end
  end

  assign m_axi_awaddr  = wr_addr_q;
  assign m_axi_awid    = AXID;
  assign m_axi_awlen   = wr_len_q;
  assign m_axi_awsize  = AXSIZE;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = u_wr_data;
  assign m_axi_wstrb   = u_wr_strb;
  assign m_axi_wlast   = (wr_st == WDATA) & w_last;
  assign u_wr_ren      = w_beat;
  assign u_wr_done     = wr_done_q;
  assign u_wr_resp     = wr_resp_q;

  // ---------------- read channel ----------------
  rd_state_e             rd_st, rd_nx;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [LEN_WIDTH-1:0]  rd_len_q;
  logic                  rd_done_q;
  logic [1:0]            rd_resp_q;
  logic [1:0]            rd_acc_q, rd_acc_nx;
  logic                  r_load, r_beat, r_last;

  always_comb begin
    rd_nx         = rd_st;
    u_rd_gnt      = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (rd_st)
      RIDLE: begin
        if (u_rd_req) begin
          u_rd_gnt = 1'b1;
          rd_nx    = RADDR;
        end
      end
      RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) rd_nx = RDATA;
      end
      RDATA: begin
        m_axi_rready = u_rd_wok;
        if (u_rd_wok && m_axi_rvalid && m_axi_rlast) rd_nx = RIDLE;
      end
      default: rd_nx = RIDLE;
    endcase
  end

  assign r_load = m_axi_arvalid & m_axi_arready;
  assign r_beat = m_axi_rvalid & m_axi_rready;

  axi_burst_beat_ctr #(.LEN_WIDTH(LEN_WIDTH)) u_r_ctr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (r_load),
    .len     (rd_len_q),
    .beat    (r_beat),
    .last    (r_last)
  );

  // RLAST disagreeing with the beat count marks a short/long burst.
  always_comb begin
    rd_acc_nx = resp_max(rd_acc_q, m_axi_rresp);
    if (r_last != m_axi_rlast) begin
      rd_acc_nx = resp_max(rd_acc_nx, AXI_RESP_SLVERR);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_st     <= RIDLE;
      rd_addr_q <= '0;
      rd_len_q  <= '0;
      rd_done_q <= 1'b0;
      rd_resp_q <= AXI_RESP_OKAY;
      rd_acc_q  <= AXI_RESP_OKAY;
    end else begin
      rd_st     <= rd_nx;
      rd_done_q <= r_beat & m_axi_rlast;
      if (u_rd_gnt) begin
        rd_addr_q <= u_rd_addr;
        rd_len_q  <= u_rd_len;
        rd_acc_q  <= AXI_RESP_OKAY;
      end else if (r_beat) begin
        rd_acc_q  <= rd_acc_nx;
      end
      if (r_beat && m_axi_rlast) rd_resp_q <= rd_acc_nx;
    end
  end

  assign m_axi_araddr  = rd_addr_q;
  assign m_axi_arid    = AXID;
  assign m_axi_arlen   = rd_len_q;
  assign m_axi_arsize  = AXSIZE;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arprot  = 3'b000;
  assign u_rd_wen      = r_beat;
  assign u_rd_data     = m_axi_rdata;
  assign u_rd_done     = rd_done_q;
  assign u_rd_resp     = rd_resp_q;

`ifdef AXI_MASTER_ERR_LATCH_EN
  // Done pulses fire while the txn's address latch is still intact.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      u_err      <= 1'b0;
      u_err_addr <= '0;
    end else if (u_err_clr) begin
      u_err      <= 1'b0;
    end else if (!u_err) begin
      if (wr_done_q && wr_resp_q != AXI_RESP_OKAY) begin
        u_err      <= 1'b1;
        u_err_addr <= wr_addr_q;
      end else if (rd_done_q && rd_resp_q != AXI_RESP_OKAY) begin
        u_err      <= 1'b1;
        u_err_addr <= rd_addr_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed self-checking bench for axi_burst_master.
// Drives 1ns after rising edge, samples 1ns later.
module tb_axi_burst_master;

  logic        aclk;
  logic        aresetn;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [3:0]  m_axi_awid;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic [3:0]  m_axi_bid;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arid;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic [3:0]  m_axi_rid;
  logic        u_wr_req, u_wr_gnt;
  logic [31:0] u_wr_addr;
  logic [7:0]  u_wr_len;
  logic        u_wr_rok, u_wr_ren;
  logic [31:0] u_wr_data;
  logic [3:0]  u_wr_strb;
  logic        u_wr_done;
  logic [1:0]  u_wr_resp;
  logic        u_rd_req, u_rd_gnt;
  logic [31:0] u_rd_addr;
  logic [7:0]  u_rd_len;
  logic        u_rd_wok, u_rd_wen;
  logic [31:0] u_rd_data;
  logic        u_rd_done;
  logic [1:0]  u_rd_resp;
`ifdef AXI_MASTER_ERR_LATCH_EN
  logic        u_err;
  logic [31:0] u_err_addr;
  logic        u_err_clr;
`endif

  int errs;
  int checks;

  axi_burst_master dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awid    (m_axi_awid),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awprot  (m_axi_awprot),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bid     (m_axi_bid),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arid    (m_axi_arid),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rid     (m_axi_rid),
    .u_wr_req      (u_wr_req),
    .u_wr_gnt      (u_wr_gnt),
    .u_wr_addr     (u_wr_addr),
    .u_wr_len      (u_wr_len),
    .u_wr_rok      (u_wr_rok),
    .u_wr_ren      (u_wr_ren),
    .u_wr_data     (u_wr_data),
    .u_wr_strb     (u_wr_strb),
    .u_wr_done     (u_wr_done),
    .u_wr_resp     (u_wr_resp),
    .u_rd_req      (u_rd_req),
    .u_rd_gnt      (u_rd_gnt),
    .u_rd_addr     (u_rd_addr),
    .u_rd_len      (u_rd_len),
    .u_rd_wok      (u_rd_wok),
    .u_rd_wen      (u_rd_wen),
    .u_rd_data     (u_rd_data),
`ifdef AXI_MASTER_ERR_LATCH_EN
    .u_rd_done     (u_rd_done),
    .u_rd_resp     (u_rd_resp),
    .u_err         (u_err),
    .u_err_addr    (u_err_addr),
    .u_err_clr     (u_err_clr)
`else
    .u_rd_done     (u_rd_done),
    .u_rd_resp     (u_rd_resp)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len,
                          input int aw_dly, input logic [1:0] bresp);
    u_wr_req  = 1'b1;
    u_wr_addr = addr;
    u_wr_len  = len;
    #1;
    chk("wr_gnt", 32'(u_wr_gnt), 32'd1);
    chk("aw_early", 32'(m_axi_awvalid), 32'd0);
    step();
    u_wr_req  = 1'b0;
    u_wr_addr = 32'hDEAD_0000;
    for (int i = 0; i <= aw_dly; i++) begin
      m_axi_awready = (i == aw_dly);
      #1;
      chk("awvalid", 32'(m_axi_awvalid), 32'd1);
      chk("awaddr", m_axi_awaddr, addr);
      chk("awlen", 32'(m_axi_awlen), 32'(len));
      step();
    end
    m_axi_awready = 1'b0;
    u_wr_rok      = 1'b1;
    m_axi_wready  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      u_wr_data = 32'hA000_0000 + 32'(i);
      #1;
      chk("wr_ren", 32'(u_wr_ren), 32'd1);
      chk("wlast", 32'(m_axi_wlast), 32'(i == int'(len)));
      chk("wdata", m_axi_wdata, 32'hA000_0000 + 32'(i));
      step();
    end
    u_wr_rok     = 1'b0;
    m_axi_wready = 1'b0;
    #1;
    chk("wvalid_off", 32'(m_axi_wvalid), 32'd0);
    chk("bready", 32'(m_axi_bready), 32'd1);
    chk("wr_done_early", 32'(u_wr_done), 32'd0);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = bresp;
    step();
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    #1;
    chk("wr_done", 32'(u_wr_done), 32'd1);
    chk("wr_resp", 32'(u_wr_resp), 32'(bresp));
    chk("bready_off", 32'(m_axi_bready), 32'd0);
    step();
    chk("wr_done_pulse", 32'(u_wr_done), 32'd0);
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len,
                          input int nbeats, input int bad,
                          input logic [1:0] bad_resp, input bit tog,
                          input logic [1:0] exp_resp);
    int k;
    int cyc;
    u_rd_req  = 1'b1;
    u_rd_addr = addr;
    u_rd_len  = len;
    #1;
    chk("rd_gnt", 32'(u_rd_gnt), 32'd1);
    step();
    u_rd_req      = 1'b0;
    m_axi_arready = 1'b1;
    #1;
    chk("arvalid", 32'(m_axi_arvalid), 32'd1);
    chk("araddr", m_axi_araddr, addr);
    chk("arlen", 32'(m_axi_arlen), 32'(len));
    chk("arsize", 32'(m_axi_arsize), 32'd2);
    step();
    m_axi_arready = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < nbeats && cyc < 64) begin
      u_rd_wok     = tog ? (cyc % 2 == 0) : 1'b1;
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = 32'hB000_0000 + 32'(k);
      m_axi_rresp  = (k == bad) ? bad_resp : 2'b00;
      m_axi_rlast  = (k == nbeats - 1);
      #1;
      chk("rready", 32'(m_axi_rready), 32'(u_rd_wok));
      chk("rd_done_early", 32'(u_rd_done), 32'd0);
      if (u_rd_wok) begin
        chk("rd_wen", 32'(u_rd_wen), 32'd1);
        chk("rd_data", u_rd_data, 32'hB000_0000 + 32'(k));
        k++;
      end else begin
        chk("rd_wen_idle", 32'(u_rd_wen), 32'd0);
      end
      step();
      cyc++;
    end
    if (k != nbeats) chk("rd_timeout", 32'(k), 32'(nbeats));
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
    u_rd_wok     = 1'b1;
    #1;
    chk("rd_done", 32'(u_rd_done), 32'd1);
    chk("rd_resp", 32'(u_rd_resp), 32'(exp_resp));
    chk("rready_off", 32'(m_axi_rready), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    errs = 0;
    checks = 0;
    aresetn = 1'b0;
    m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0;
    m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rid = 0;
    u_wr_req = 0; u_wr_addr = 0; u_wr_len = 0; u_wr_rok = 0;
    u_wr_data = 0; u_wr_strb = 4'hF;
    u_rd_req = 0; u_rd_addr = 0; u_rd_len = 0; u_rd_wok = 0;
`ifdef AXI_MASTER_ERR_LATCH_EN
    u_err_clr = 0;
`endif
    m_axi_bvalid = 1'b1;
    m_axi_rvalid = 1'b1;
    step();
    step();
    aresetn = 1'b1;
    #1;
    chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
    chk("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("rst_bready", 32'(m_axi_bready), 32'd0);
    chk("rst_rready", 32'(m_axi_rready), 32'd0);
    chk("rst_done", 32'({u_wr_done, u_rd_done}), 32'd0);
    chk("rst_resp", 32'({u_wr_resp, u_rd_resp}), 32'd0);
    step();
    m_axi_bvalid = 1'b0;
    m_axi_rvalid = 1'b0;
    #1;
    chk("awburst", 32'(m_axi_awburst), 32'd1);
    chk("awsize", 32'(m_axi_awsize), 32'd2);
    chk("awprot", 32'(m_axi_awprot), 32'd0);
    chk("awid", 32'(m_axi_awid), 32'd0);
    step();

    wr_burst(32'h0000_1000, 8'd3, 0, 2'b00);
    wr_burst(32'h0000_2040, 8'd0, 5, 2'b00);

    rd_burst(32'h0000_4000, 8'd7, 8, -1, 2'b00, 1'b1, 2'b00);
    rd_burst(32'h0000_5000, 8'd3, 2, -1, 2'b00, 1'b0, 2'b10);
    rd_burst(32'h0000_6000, 8'd3, 3, 2, 2'b11, 1'b0, 2'b11);
    rd_burst(32'h0000_7000, 8'd1, 3, -1, 2'b00, 1'b0, 2'b10);

    // simultaneous write and read, interleaved beats
    u_wr_req = 1'b1; u_wr_addr = 32'h8000; u_wr_len = 8'd1;
    u_rd_req = 1'b1; u_rd_addr = 32'h9000; u_rd_len = 8'd1;
    #1;
    chk("both_wr_gnt", 32'(u_wr_gnt), 32'd1);
    chk("both_rd_gnt", 32'(u_rd_gnt), 32'd1);
    step();
    u_wr_req = 1'b0; u_rd_req = 1'b0;
    m_axi_awready = 1'b1; m_axi_arready = 1'b1;
    #1;
    chk("both_aw", 32'(m_axi_awvalid), 32'd1);
    chk("both_ar", 32'(m_axi_arvalid), 32'd1);
    step();
    m_axi_awready = 1'b0; m_axi_arready = 1'b0;
    u_wr_rok = 1'b1; m_axi_wready = 1'b1;
    u_rd_wok = 1'b1; m_axi_rvalid = 1'b1;
    u_wr_req = 1'b1; u_rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      u_wr_data   = 32'hC000_0000 + 32'(i);
      m_axi_rdata = 32'hD000_0000 + 32'(i);
      m_axi_rlast = (i == 1);
      #1;
      chk("busy_wr_gnt", 32'(u_wr_gnt), 32'd0);
      chk("busy_rd_gnt", 32'(u_rd_gnt), 32'd0);
      chk("il_ren", 32'(u_wr_ren), 32'd1);
      chk("il_wen", 32'(u_rd_wen), 32'd1);
      chk("il_wlast", 32'(m_axi_wlast), 32'(i == 1));
      chk("il_rdata", u_rd_data, 32'hD000_0000 + 32'(i));
      step();
    end
    u_wr_req = 1'b0; u_rd_req = 1'b0;
    u_wr_rok = 1'b0; m_axi_wready = 1'b0;
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    #1;
    chk("il_rd_done", 32'(u_rd_done), 32'd1);
    chk("il_rd_resp", 32'(u_rd_resp), 32'd0);
    chk("il_bready", 32'(m_axi_bready), 32'd1);
    m_axi_bvalid = 1'b1; m_axi_bresp = 2'b10;
    step();
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    #1;
    chk("il_wr_done", 32'(u_wr_done), 32'd1);
    chk("il_wr_resp", 32'(u_wr_resp), 32'd2);
    step();

    // reset during second write beat
    u_wr_req = 1'b1; u_wr_addr = 32'hA000; u_wr_len = 8'd3;
    step();
    u_wr_req = 1'b0;
    m_axi_awready = 1'b1;
    step();
    m_axi_awready = 1'b0;
    u_wr_rok = 1'b1; m_axi_wready = 1'b1;
    #1;
    chk("mid_beat1", 32'(u_wr_ren), 32'd1);
    step();
    aresetn = 1'b0;
    #1;
    chk("mid_wvalid", 32'(m_axi_wvalid), 32'd0);
    chk("mid_ren", 32'(u_wr_ren), 32'd0);
    chk("mid_wlast", 32'(m_axi_wlast), 32'd0);
    chk("mid_awvalid", 32'(m_axi_awvalid), 32'd0);
    chk("mid_wr_resp", 32'(u_wr_resp), 32'd0);
    step();
    u_wr_rok = 1'b0; m_axi_wready = 1'b0;
    aresetn = 1'b1;
    step();
    wr_burst(32'h0000_3000, 8'd0, 0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
